// File: rtl/eth_tx_sched_pkg.sv
// eth_tx_sched_pkg: shared state encoding and queue indices for the
// two-queue Ethernet transmit scheduler.
package eth_tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      IFG  = 2'd2
   } sched_state_e;

   localparam int Q_HI  = 0;
   localparam int Q_LO  = 1;
   localparam int NUM_Q = 2;

endpackage

// File: rtl/eth_tx_sched_if.sv
// eth_tx_sched_if: FIFO-side, MAC-side and status signals of the scheduler.
// master = scheduler, slave = FIFOs/MAC/environment.
// Optional statistics signals exist only with ETH_TX_SCHED_STATS_EN.
interface eth_tx_sched_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 2
);
   import eth_tx_sched_pkg::*;

   logic [NUM_Q-1:0]  pct_qued;
   logic [NUM_Q-1:0]  fifo_empty;
   logic [DATA_W-1:0] fifo_dout0;
   logic [DATA_W-1:0] fifo_dout1;
   logic [NUM_Q-1:0]  fifo_last;
   logic [NUM_Q-1:0]  fifo_rd_en;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_last;
   logic              tx_ready;
   logic [NUM_Q-1:0]  pct_txed;
   logic [CNT_W-1:0]  pkt_cnt0;
   logic [CNT_W-1:0]  pkt_cnt1;
   logic [NUM_Q-1:0]  cnt_ovf;
   logic              busy;
`ifdef ETH_TX_SCHED_STATS_EN
   logic [15:0]       frm_cnt0;
   logic [15:0]       frm_cnt1;
   logic [15:0]       stall_cnt;
`endif

   modport master (
      input  pct_qued, fifo_empty, fifo_dout0, fifo_dout1, fifo_last, tx_ready,
      output fifo_rd_en, tx_data, tx_valid, tx_last, pct_txed,
      output pkt_cnt0, pkt_cnt1, cnt_ovf, busy
`ifdef ETH_TX_SCHED_STATS_EN
      , output frm_cnt0, frm_cnt1, stall_cnt
`endif
   );

   modport slave (
      output pct_qued, fifo_empty, fifo_dout0, fifo_dout1, fifo_last, tx_ready,
      input  fifo_rd_en, tx_data, tx_valid, tx_last, pct_txed,
      input  pkt_cnt0, pkt_cnt1, cnt_ovf, busy
`ifdef ETH_TX_SCHED_STATS_EN
      , input frm_cnt0, frm_cnt1, stall_cnt
`endif
   );

endinterface

// File: rtl/eth_tx_sched_cnt.sv
// tx_pkt_counter: per-queue pending-packet counter. Counts up on a queued
// pulse, down on a transmitted pulse, holds when both or neither arrive.
// Saturates at all-ones and raises a sticky overflow flag instead of wrapping.
module tx_pkt_counter #(
   parameter int CNT_W = 2
) (
   input  logic             eth_tx_clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   // Next count: saturating increment, plain decrement (grant logic keeps it above 0).
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (inc && !dec) begin
         if (&cnt_q) ovf_d = 1'b1;
         else        cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter state, synchronous active-low reset.
   always_ff @(posedge eth_tx_clk) begin
      if (!rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt = cnt_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: two-queue transmit scheduler. Strict priority for queue 0
// with a starvation limit for queue 1, one frame per grant, then an
// inter-frame gap. Optional statistics under ETH_TX_SCHED_STATS_EN.
module eth_tx_sched
   import eth_tx_sched_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CNT_W      = 2,
   parameter int HI_BURST   = 4,
   parameter int IFG_CYCLES = 12
) (
   input logic            eth_tx_clk,
   input logic            rst,
   eth_tx_sched_if.master bus
);
   localparam int BURST_W  = $clog2(HI_BURST + 1);
   localparam int IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam int IFG_LOAD = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

   sched_state_e       state_q, state_d;
   logic               sel_q, sel_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [IFG_W-1:0]   ifg_q, ifg_d;
   logic [NUM_Q-1:0]   txed_q, txed_d;

   logic [CNT_W-1:0]   cnt [NUM_Q];
   logic [NUM_Q-1:0]   ovf, avail;
   logic               head_empty, head_last, tx_valid_c, beat_acc;
   logic [DATA_W-1:0]  head_data;

   // A queue is grantable when it holds a packet not already being retired
   // by a pct_txed pulse still in flight (matters only for very short gaps).
   for (genvar q = 0; q < NUM_Q; q++) begin : g_cnt
      tx_pkt_counter #(.CNT_W(CNT_W)) u_cnt (
         .eth_tx_clk (eth_tx_clk),
         .rst        (rst),
         .inc        (bus.pct_qued[q]),
         .dec        (txed_q[q]),
         .cnt        (cnt[q]),
         .ovf        (ovf[q])
      );
      assign avail[q] = (cnt[q] != '0) && !(txed_q[q] && (cnt[q] == CNT_W'(1)));
   end

   assign head_empty = sel_q ? bus.fifo_empty[Q_LO] : bus.fifo_empty[Q_HI];
   assign head_last  = sel_q ? bus.fifo_last[Q_LO]  : bus.fifo_last[Q_HI];
   assign head_data  = sel_q ? bus.fifo_dout1       : bus.fifo_dout0;
   assign tx_valid_c = (state_q == XFER) && !head_empty;
   assign beat_acc   = tx_valid_c && bus.tx_ready;

   assign bus.tx_valid   = tx_valid_c;
   assign bus.tx_data    = tx_valid_c ? head_data : '0;
   assign bus.tx_last    = tx_valid_c && head_last;
   assign bus.fifo_rd_en = beat_acc ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus.pct_txed   = txed_q;
   assign bus.pkt_cnt0   = cnt[Q_HI];
   assign bus.pkt_cnt1   = cnt[Q_LO];
   assign bus.cnt_ovf    = ovf;
   assign bus.busy       = (state_q != IDLE);

   // Scheduler next state: grant arbitration, frame end detection, gap countdown.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      burst_d = burst_q;
      ifg_d   = ifg_q;
      txed_d  = '0;
      case (state_q)
         IDLE: begin
            if (avail[Q_HI] && avail[Q_LO]) begin
               state_d = XFER;
               if (burst_q == BURST_W'(HI_BURST)) begin
                  sel_d   = 1'b1;
                  burst_d = '0;
               end else begin
                  sel_d   = 1'b0;
                  burst_d = burst_q + 1'b1;
               end
            end else if (avail[Q_HI] || avail[Q_LO]) begin
               state_d = XFER;
               sel_d   = avail[Q_LO];
               burst_d = '0;
            end
         end
         XFER: begin
            if (beat_acc && head_last) begin
               txed_d = sel_q ? 2'b10 : 2'b01;
               if (IFG_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = IFG;
                  ifg_d   = IFG_W'(IFG_LOAD);
               end
            end
         end
         IFG: begin
            if (ifg_q == '0) state_d = IDLE;
            else             ifg_d   = ifg_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scheduler registers; reset abandons any frame in progress.
   always_ff @(posedge eth_tx_clk) begin
      if (!rst) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         burst_q <= '0;
         ifg_q   <= '0;
         txed_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         burst_q <= burst_d;
         ifg_q   <= ifg_d;
         txed_q  <= txed_d;
      end
   end

`ifdef ETH_TX_SCHED_STATS_EN
   logic [15:0] frm0_q, frm0_d, frm1_q, frm1_d, stall_q, stall_d;

   // Frame counts wrap; stall count saturates on XFER cycles without data.
   always_comb begin
      frm0_d  = frm0_q + {15'd0, txed_q[Q_HI]};
      frm1_d  = frm1_q + {15'd0, txed_q[Q_LO]};
      stall_d = stall_q;
      if ((state_q == XFER) && !tx_valid_c && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   // Statistics registers.
   always_ff @(posedge eth_tx_clk) begin
      if (!rst) begin
         frm0_q  <= '0;
         frm1_q  <= '0;
         stall_q <= '0;
      end else begin
         frm0_q  <= frm0_d;
         frm1_q  <= frm1_d;
         stall_q <= stall_d;
      end
   end

   assign bus.frm_cnt0  = frm0_q;
   assign bus.frm_cnt1  = frm1_q;
   assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: directed bench with a FIFO model and a cycle-level
// behavioural scoreboard of the scheduler, plus literal checks per scenario.
module tb_eth_tx_sched;
   localparam int DATA_W     = 8;
   localparam int CNT_W      = 2;
   localparam int HI_BURST   = 4;
   localparam int IFG_CYCLES = 12;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   eth_tx_sched_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   eth_tx_sched #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .HI_BURST(HI_BURST), .IFG_CYCLES(IFG_CYCLES)
   ) dut (
      .eth_tx_clk (clk),
      .rst        (rst),
      .bus        (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, want);
   endtask

   // ---------------- FIFO model (FWFT) ----------------
   logic [DATA_W:0] fq0[$];
   logic [DATA_W:0] fq1[$];
   logic [1:0]      force_empty = 2'b00;

   task automatic drive_fifo();
      bus.fifo_empty[0] = (fq0.size() == 0) || force_empty[0];
      bus.fifo_empty[1] = (fq1.size() == 0) || force_empty[1];
      bus.fifo_dout0    = (fq0.size() != 0) ? fq0[0][DATA_W-1:0] : '0;
      bus.fifo_dout1    = (fq1.size() != 0) ? fq1[0][DATA_W-1:0] : '0;
      bus.fifo_last[0]  = (fq0.size() != 0) ? fq0[0][DATA_W] : 1'b0;
      bus.fifo_last[1]  = (fq1.size() != 0) ? fq1[0][DATA_W] : 1'b0;
   endtask

   task automatic set_force(input logic [1:0] v);
      force_empty = v;
      drive_fifo();
   endtask

   task automatic push_frame(input int q, input int n, input logic [7:0] base);
      logic [DATA_W:0] w;
      for (int i = 0; i < n; i++) begin
         w = {(i == n - 1), base + 8'(i)};
         if (q == 0) fq0.push_back(w);
         else        fq1.push_back(w);
      end
      drive_fifo();
   endtask

   // Snapshot of the cycle just completed (sampled at negedge).
   logic       s_valid, s_last, s_ready, s_busy;
   logic [7:0] s_data;
   logic [1:0] s_rd, s_txed;

   task automatic tick();
      logic [1:0] rd;
      @(negedge clk);
      s_valid = bus.tx_valid;  s_last = bus.tx_last;   s_ready = bus.tx_ready;
      s_busy  = bus.busy;      s_data = bus.tx_data;   s_rd    = bus.fifo_rd_en;
      s_txed  = bus.pct_txed;  rd     = bus.fifo_rd_en;
      @(posedge clk);
      #1;
      if (rd[0]) void'(fq0.pop_front());
      if (rd[1]) void'(fq1.pop_front());
      drive_fifo();
   endtask

   task automatic pulse(input logic [1:0] m);
      bus.pct_qued = m;
      tick();
      bus.pct_qued = 2'b00;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      do begin tick(); n++; end while (!s_valid && n < 50);
      chk(name, s_valid, 1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin tick(); n++; end while (s_busy && n < 100);
      chk(name, s_busy, 0);
   endtask

   // ---------------- behavioural scoreboard ----------------
   // cur_q: queue whose frame is streaming (-1 none); gap_left: gap cycles still owed.
   bit         model_on = 1'b0;
   int         cur_q    = -1;
   int         gap_left = 0;
   int         m_cnt[2] = '{0, 0};
   bit         m_ovf[2] = '{0, 0};
   logic [1:0] m_txed   = 2'b00;
   int         m_burst  = 0;
   int         m_frm[2] = '{0, 0};
   int         m_stall  = 0;
   logic       e_valid, e_last;
   logic [1:0] e_rd, new_txed;
   logic [7:0] e_data;
   bit         a0, a1;

   always @(negedge clk) begin
      if (model_on) begin
         e_valid = (cur_q >= 0) && !bus.fifo_empty[cur_q];
         e_last  = e_valid && bus.fifo_last[cur_q];
         e_data  = (cur_q == 1) ? bus.fifo_dout1 : bus.fifo_dout0;
         e_rd    = (e_valid && bus.tx_ready) ? ((cur_q == 1) ? 2'b10 : 2'b01) : 2'b00;
         chk("tx_valid", bus.tx_valid, e_valid);
         chk("tx_last", bus.tx_last, e_last);
         chk("fifo_rd_en", bus.fifo_rd_en, e_rd);
         if (e_valid) chk("tx_data", bus.tx_data, e_data);
         chk("busy", bus.busy, (cur_q >= 0) || (gap_left > 0));
         chk("pkt_cnt0", bus.pkt_cnt0, m_cnt[0]);
         chk("pkt_cnt1", bus.pkt_cnt1, m_cnt[1]);
         chk("cnt_ovf", bus.cnt_ovf, {m_ovf[1], m_ovf[0]});
         chk("pct_txed", bus.pct_txed, m_txed);
`ifdef ETH_TX_SCHED_STATS_EN
         chk("frm_cnt0", bus.frm_cnt0, m_frm[0]);
         chk("frm_cnt1", bus.frm_cnt1, m_frm[1]);
         chk("stall_cnt", bus.stall_cnt, m_stall);
`endif
         if (!rst) begin
            cur_q = -1; gap_left = 0; m_cnt = '{0, 0}; m_ovf = '{0, 0};
            m_txed = 2'b00; m_burst = 0; m_frm = '{0, 0}; m_stall = 0;
         end else begin
            if (cur_q >= 0 && !e_valid && m_stall < 65535) m_stall++;
            for (int q = 0; q < 2; q++) if (m_txed[q]) m_frm[q] = (m_frm[q] + 1) % 65536;
            new_txed = 2'b00;
            if (cur_q >= 0) begin
               if (e_valid && bus.tx_ready && e_last) begin
                  new_txed[cur_q] = 1'b1;
                  cur_q    = -1;
                  gap_left = IFG_CYCLES;
               end
            end else if (gap_left > 0) begin
               gap_left--;
            end else begin
               a0 = (m_cnt[0] - int'(m_txed[0])) > 0;
               a1 = (m_cnt[1] - int'(m_txed[1])) > 0;
               if (a0 && a1) begin
                  if (m_burst >= HI_BURST) begin cur_q = 1; m_burst = 0; end
                  else begin cur_q = 0; m_burst++; end
               end else if (a0) begin cur_q = 0; m_burst = 0; end
               else if (a1)     begin cur_q = 1; m_burst = 0; end
            end
            for (int q = 0; q < 2; q++) begin
               if (bus.pct_qued[q] && !m_txed[q]) begin
                  if (m_cnt[q] == CNT_MAX) m_ovf[q] = 1'b1;
                  else m_cnt[q]++;
               end else if (m_txed[q] && !bus.pct_qued[q]) begin
                  m_cnt[q]--;
               end
            end
            m_txed = new_txed;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int beats, last_beat, txed, gap, n, rep;
      bit seen_last, pend;
      int got[$];
      int exp_ord[8];
`ifdef ETH_TX_SCHED_STATS_EN
      logic [15:0] st0, fr0;
`endif
      bus.pct_qued = 2'b00;
      bus.tx_ready = 1'b1;
      drive_fifo();

      // Reset state
      rst = 1'b0;
      @(posedge clk); #1;
      model_on = 1'b1;
      tick(); tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.tx_valid, 0);
      chk("rst_cnt0", bus.pkt_cnt0, 0);
      chk("rst_cnt1", bus.pkt_cnt1, 0);
      chk("rst_ovf", bus.cnt_ovf, 0);
      rst = 1'b1;

      // Single 3-beat frame on queue 1
      push_frame(1, 3, 8'h10);
      pulse(2'b10);
      chk("t1_cnt1_up", bus.pkt_cnt1, 1);
      beats = 0; last_beat = 0; txed = 0; gap = 0; seen_last = 0; n = 0;
      do begin
         tick(); n++;
         if (seen_last && s_busy) gap++;
         if (s_valid && s_ready) begin
            beats++;
            if (s_last) begin last_beat = beats; seen_last = 1; end
         end
         if (s_txed == 2'b10) txed++;
      end while ((s_busy || !seen_last) && n < 60);
      chk("t1_beats", beats, 3);
      chk("t1_last_beat", last_beat, 3);
      chk("t1_txed_pulses", txed, 1);
      chk("t1_ifg_cycles", gap, 12);
      chk("t1_cnt1_down", bus.pkt_cnt1, 0);

      // Priority and starvation limit: 6 q0 + 2 q1 single-beat frames
      set_force(2'b11);
      for (int i = 0; i < 6; i++) push_frame(0, 1, 8'h20 + 8'(i));
      for (int i = 0; i < 2; i++) push_frame(1, 1, 8'h30 + 8'(i));
      pulse(2'b11); pulse(2'b11); pulse(2'b01);
      set_force(2'b00);
      rep = 0; pend = 0; n = 0;
      while (got.size() < 8 && n < 400) begin
         bus.pct_qued = pend ? 2'b01 : 2'b00;
         tick(); n++;
         bus.pct_qued = 2'b00;
         if (pend) begin pend = 0; rep++; end
         if (s_txed[0] && rep < 3) pend = 1;
         if (s_valid && s_ready && s_last) got.push_back(int'(s_rd[1]));
      end
      exp_ord = '{0, 0, 0, 0, 1, 0, 0, 1};
      chk("t2_grant_count", got.size(), 8);
      for (int i = 0; i < got.size(); i++) chk($sformatf("t2_grant%0d", i), got[i], exp_ord[i]);
      wait_idle("t2_idle");

      // Backpressure: ready 1,0,0,1
      push_frame(1, 4, 8'h40);
      pulse(2'b10);
      wait_valid("t3_start");
      beats = 1;
      for (int i = 0; i < 3; i++) begin
         bus.tx_ready = (i == 2);
         tick();
         if (i < 2) begin
            chk("t3_hold_valid", s_valid, 1);
            chk("t3_hold_data", s_data, 8'h41);
            chk("t3_hold_rd", s_rd, 2'b00);
         end else begin
            chk("t3_rd_on_ready", s_rd, 2'b10);
         end
         if (s_valid && s_ready) beats++;
      end
      bus.tx_ready = 1'b1;
      n = 0;
      do begin
         tick(); n++;
         if (s_valid && s_ready) beats++;
      end while (s_txed == 2'b00 && n < 50);
      chk("t3_beats", beats, 4);
      wait_idle("t3_idle");

      // FIFO underrun for 3 cycles mid-frame
`ifdef ETH_TX_SCHED_STATS_EN
      st0 = bus.stall_cnt;
      fr0 = bus.frm_cnt0;
`endif
      push_frame(0, 4, 8'h50);
      pulse(2'b01);
      wait_valid("t4_start");
      beats = 1; txed = 0;
      set_force(2'b01);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_valid_low", s_valid, 0);
      end
      set_force(2'b00);
      n = 0;
      do begin
         tick(); n++;
         if (s_valid && s_ready) beats++;
         if (s_txed == 2'b01) txed++;
      end while (s_busy && n < 60);
      chk("t4_beats", beats, 4);
      chk("t4_txed_pulses", txed, 1);
`ifdef ETH_TX_SCHED_STATS_EN
      chk("t4_stall_delta", bus.stall_cnt - st0, 3);
      chk("t4_frm_delta", bus.frm_cnt0 - fr0, 1);
`endif

      // Counter saturation, then pct_qued coinciding with pct_txed
      for (int i = 0; i < 4; i++) pulse(2'b01);
      chk("t5_cnt0_sat", bus.pkt_cnt0, 3);
      chk("t5_ovf", bus.cnt_ovf, 2'b01);
      push_frame(0, 1, 8'h60);
      n = 0;
      do begin tick(); n++; end while (!(s_valid && s_ready && s_last) && n < 50);
      chk("t5_beat", s_last, 1);
      pulse(2'b01);
      chk("t5_txed", s_txed, 2'b01);
      chk("t5_cnt0_hold", bus.pkt_cnt0, 3);
      chk("t5_ovf_sticky", bus.cnt_ovf, 2'b01);

      // Mid-frame reset on beat 2 of 5
      push_frame(0, 5, 8'h70);
      wait_valid("t6_start");
      rst = 1'b0;
      tick();
      chk("t6_beat2", s_data, 8'h71);
      chk("t6_valid", bus.tx_valid, 0);
      chk("t6_last", bus.tx_last, 0);
      chk("t6_data", bus.tx_data, 0);
      chk("t6_rd", bus.fifo_rd_en, 0);
      chk("t6_txed", bus.pct_txed, 0);
      chk("t6_busy", bus.busy, 0);
      chk("t6_cnt0", bus.pkt_cnt0, 0);
      chk("t6_cnt1", bus.pkt_cnt1, 0);
      chk("t6_ovf", bus.cnt_ovf, 0);
      rst = 1'b1;
      fq0.delete();
      drive_fifo();
      push_frame(1, 2, 8'h80);
      pulse(2'b10);
      wait_valid("t6_regrant");
      chk("t6_regrant_q", s_rd, 2'b10);
      wait_idle("t6_idle");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
